// File: rtl/cpu_cu.sv
// cpu_cu: multi-cycle fetch/decode/execute control unit for the 16-bit CPU.
// Drives the execution unit's control strobes and the RAM write enable from
// the current state, the instruction class ir[11:9] and flags captured in EXEC.
module cpu_cu (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        carry,
  input  logic        N,
  input  logic        Z,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        ir_ld,
  output logic        adr_sel,
  output logic        S_Sel,
  output logic        W_En,
  output logic        mem_we,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_LD_ADR = 4'd4,
    S_LD_WB  = 4'd5,
    S_ST     = 4'd6,
    S_JMP    = 4'd7,
    S_BR     = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next;
  state_t     w_end;
  logic       r_cf, r_nf, r_zf;
  logic [2:0] w_cls;
  logic       w_unused_ir;

  assign w_cls       = ir[11:9];
  // Remaining IR fields belong to the execution unit.
  assign w_unused_ir = ^{ir[15:12], ir[8:0]};
  // Instruction end: continue fetching only while run is held.
  assign w_end       = run ? S_FETCH : S_IDLE;

  // State register; reset wins over every transition, including HALT.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // ALU flags are captured only in EXEC so branches see the last ALU result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cf <= 1'b0;
      r_nf <= 1'b0;
      r_zf <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_cf <= carry;
      r_nf <= N;
      r_zf <= Z;
    end
  end

  // Next-state and Moore outputs; everything is forced low while reset is high.
  always_comb begin
    w_next  = S_IDLE;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    ir_ld   = 1'b0;
    adr_sel = 1'b0;
    S_Sel   = 1'b0;
    W_En    = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    case (r_state)
      S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_cls)
          3'b000:                 w_next = S_EXEC;
          3'b001:                 w_next = S_LD_ADR;
          3'b010:                 w_next = S_ST;
          3'b011:                 w_next = S_JMP;
          3'b100, 3'b101, 3'b110: w_next = S_BR;
          default:                w_next = S_HALT;
        endcase
      end
      S_EXEC: begin
        W_En   = 1'b1;
        w_next = w_end;
      end
      S_LD_ADR: begin
        adr_sel = 1'b1;
        w_next  = S_LD_WB;
      end
      S_LD_WB: begin
        adr_sel = 1'b1;
        S_Sel   = 1'b1;
        W_En    = 1'b1;
        w_next  = w_end;
      end
      S_ST: begin
        adr_sel = 1'b1;
        mem_we  = 1'b1;
        w_next  = w_end;
      end
      S_JMP: begin
        pc_ld  = 1'b1;
        w_next = w_end;
      end
      S_BR: begin
        case (w_cls)
          3'b100:  pc_ld = r_zf;
          3'b101:  pc_ld = r_nf;
          3'b110:  pc_ld = r_cf;
          default: pc_ld = 1'b0;
        endcase
        w_next = w_end;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default:  w_next = S_IDLE;
    endcase
    if (reset) begin
      pc_inc  = 1'b0;
      pc_ld   = 1'b0;
      ir_ld   = 1'b0;
      adr_sel = 1'b0;
      S_Sel   = 1'b0;
      W_En    = 1'b0;
      mem_we  = 1'b0;
      halted  = 1'b0;
    end
  end

  assign state = reset ? 4'd0 : r_state;

endmodule
